mem_access_arbiter: RTL and testbench
=====================================

Name: mem_access_arbiter

Overview:
Shares the CPU's single 16-bit memory port between the instruction-fetch unit and the load/store unit. The block latches the granted requester's address, write flag and write data into an internal address register and drives the memory from that register for the whole access. It also sequences the fixed read latency of the synchronous RAM and returns one-cycle acknowledges to each requester. It sits between the fetch/execute logic and the RAM.

Parameters:
ADDR_W, 16, address width.
DATA_W, 16, data width.
RD_LAT, 2, RAM read latency in cycles, counted from the first cycle mem_addr is presented. Legal range 1..4.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
f_req  in  1  fetch request; held until f_ack.
f_addr  in  ADDR_W  fetch address; stable while f_req is high.
f_ack  out  1  one-cycle pulse: fetch read complete.
f_rdata  out  DATA_W  fetch read data; registered; valid in the f_ack cycle and held afterwards.
d_req  in  1  data request; held until d_ack.
d_wren  in  1  1 = write, 0 = read; stable while d_req is high.
d_addr  in  ADDR_W  data address.
d_wdata  in  DATA_W  data to write.
d_ack  out  1  one-cycle pulse: data access complete.
d_rdata  out  DATA_W  data read result; registered; held.
mem_addr  out  ADDR_W  RAM address, driven from the internal address register.
mem_wren  out  1  RAM write enable.
mem_wdata  out  DATA_W  RAM write data, driven from the latched value.
mem_rdata  in  DATA_W  RAM read data.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - f_ack, d_ack and mem_wren = 0.
  - Address register, mem_wdata, f_rdata and d_rdata = 0.
  - Latency counter = 0.
  - last_grant = FETCH, so data wins the first tie.
  - Any in-flight access is abandoned and no ack is issued for it.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Requests are sampled only in this state.
  - Neither req high: stay in IDLE.
  - Exactly one req high: grant it.
  - Both high: grant the requester that is not last_grant (round-robin).
  - On grant: latch owner, address, wren (fetch always forces wren = 0) and wdata; update last_grant; go to ISSUE.
- ISSUE (one cycle):
  - mem_addr = latched address.
  - mem_wren = latched wren. This is the only cycle mem_wren can be 1.
  - Write: go to DONE.
  - Read: go to WAIT with counter = 1.
- WAIT:
  - Counter increments each cycle.
  - When counter == RD_LAT, mem_rdata is captured into the owner's rdata register at that edge and the state goes to DONE.
  - With RD_LAT = 1, the WAIT state lasts exactly one cycle.
- DONE (one cycle):
  - The owner's ack = 1.
  - Next state is IDLE.
- Latency, measured from the IDLE edge that samples req to the ack cycle:
  - Write: ack in the 2nd cycle.
  - Read: ack in the (RD_LAT+2)th cycle.
- Handshake:
  - A requester drops req, or changes it to a new request, on the edge that ends its ack cycle.
  - Because IDLE samples one cycle after DONE, the same access can never be double-granted.
  - Inputs of a granted requester are don't-care after the grant edge, since everything needed is latched.
- A non-granted requester keeps req high; it is served next. Starvation is impossible under round-robin.
- mem_addr and mem_wdata hold their last latched values in IDLE.
- Only the owner's rdata register is updated; the other requester's rdata is unchanged.
- f_ack and d_ack are never high in the same cycle.

Test Plan:
1. Reset check: assert reset asynchronously mid-cycle -> all outputs 0 immediately, busy = 0.
2. Fetch read, RD_LAT = 2: f_addr = 0x0040; RAM model returns 0xBEEF for that address. Expected response:
   - mem_addr = 0x0040 from the ISSUE cycle onward.
   - f_ack pulses exactly in the 4th cycle after the sampling edge, with f_rdata = 0xBEEF.
   - mem_wren stays 0 throughout.
3. Data write: d_wren = 1, d_addr = 0x8001, d_wdata = 0x1234. Expected response:
   - mem_wren high for exactly one cycle, with mem_addr = 0x8001 and mem_wdata = 0x1234.
   - d_ack pulses in the next cycle.
   - RAM model holds 0x1234 at 0x8001.
4. Contention: f_req and d_req held continuously, with a new address after each ack -> grants run D, F, D, F over 4 accesses, and acks never overlap.
5. Reset mid-WAIT: assert reset 1 cycle into WAIT of a fetch read, then release -> no f_ack ever fires for that read. A fresh read of 0x0002 then completes normally with correct data.
6. Parameter sweep, RD_LAT = 1 and RD_LAT = 4: back-to-back reads -> ack in cycle 3 and cycle 6 respectively, with correct data captured from the RAM model.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one synchronous-RAM port between instruction fetch
// and load/store; latches the granted access and sequences the fixed read latency.
`timescale 1ns/1ps
module mem_access_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_wren,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_D = 1'b1;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wren_q, wren_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                grant_data;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wren_d     = wren_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    f_rdata_d  = f_rdata_q;
    d_rdata_d  = d_rdata_q;
    grant_data = 1'b0;
    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          // On a tie the side that did not win last time goes first.
          grant_data = d_req && (!f_req || (last_q == OWN_F));
          owner_d    = grant_data ? OWN_D : OWN_F;
          last_d     = grant_data ? OWN_D : OWN_F;
          addr_d     = grant_data ? d_addr : f_addr;
          wren_d     = grant_data && d_wren;
          if (grant_data) begin
            wdata_d = d_wdata;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (wren_q) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = 3'd1;
        end
      end
      WAIT: begin
        if (cnt_q == 3'(RD_LAT)) begin
          state_d = DONE;
          cnt_d   = 3'd0;
          if (owner_q == OWN_D) begin
            d_rdata_d = mem_rdata;
          end else begin
            f_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_F;
      last_q    <= OWN_F;
      addr_q    <= '0;
      wren_q    <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= 3'd0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wren_q    <= wren_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // The write strobe exists only in ISSUE; acks only in DONE, so they cannot overlap.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wren  = (state_q == ISSUE) && wren_q;
  assign f_ack     = (state_q == DONE) && (owner_q == OWN_F);
  assign d_ack     = (state_q == DONE) && (owner_q == OWN_D);
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench: three arbiter lanes (RD_LAT 2, 1, 4), each with its own RAM model,
// driven by directed and random request batches against a queue-based reference.
`timescale 1ns/1ps
module tb_mem_access_arbiter;

  localparam int N = 3;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  function automatic logic [15:0] init_val(input int a);
    if (a == 16'h0040) return 16'hBEEF;
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                 reset;
  logic [N-1:0]         f_req, d_req, d_wren, f_ack, d_ack, mem_wren, busy;
  logic [N-1:0][15:0]   f_addr, d_addr, d_wdata, f_rdata, d_rdata;
  logic [N-1:0][15:0]   mem_addr, mem_wdata, mem_rdata;

  typedef struct packed {
    logic        is_d;
    logic        wren;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sbq [N][$];
  logic [15:0] ref_m [N][65536];
  bit          last_d [N];
  logic [15:0] exp_frd [N];
  logic [15:0] exp_drd [N];
  logic [15:0] exp_ma [N];
  int          bc [N];
  int          n_cmp = 0;
  int          n_fail = 0;

  for (genvar g = 0; g < N; g++) begin : gen_lane
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [15:0] ram [65536];
    logic [15:0] pipe [4];

    mem_access_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(LAT)) dut (
      .clock     (clock),
      .reset     (reset),
      .f_req     (f_req[g]),
      .f_addr    (f_addr[g]),
      .f_ack     (f_ack[g]),
      .f_rdata   (f_rdata[g]),
      .d_req     (d_req[g]),
      .d_wren    (d_wren[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_ack     (d_ack[g]),
      .d_rdata   (d_rdata[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wren  (mem_wren[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g])
    );

    initial begin
      for (int a = 0; a < 65536; a++) ram[a] <= init_val(a);
    end

    // Synchronous RAM: data for the address presented in cycle k appears in cycle k+LAT.
    always @(posedge clock) begin
      if (mem_wren[g]) ram[mem_addr[g]] <= mem_wdata[g];
      pipe[0] <= ram[mem_addr[g]];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    assign mem_rdata[g] = pipe[LAT-1];
  end

  task automatic chk(input string nm, input int g, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s lane%0d t=%0t: got %h, required %h", nm, g, $time, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever a lane acknowledges.
  always @(negedge clock) begin
    exp_t e;
    int   el;
    for (int g = 0; g < N; g++) begin
      if (reset) begin
        bc[g] = 0;
        continue;
      end
      chk("ack_overlap", g, 16'(f_ack[g] & d_ack[g]), 16'd0);
      if (busy[g]) bc[g]++; else bc[g] = 0;
      if (!busy[g]) begin
        chk("idle_wren", g, 16'(mem_wren[g]), 16'd0);
        chk("idle_ack", g, 16'(f_ack[g] | d_ack[g]), 16'd0);
        chk("idle_mem_addr", g, mem_addr[g], exp_ma[g]);
        chk("held_f_rdata", g, f_rdata[g], exp_frd[g]);
        chk("held_d_rdata", g, d_rdata[g], exp_drd[g]);
      end else if (sbq[g].size() == 0) begin
        chk("unexpected_grant", g, 16'(busy[g]), 16'd0);
      end else begin
        e  = sbq[g][0];
        el = e.wren ? 2 : lat_of(g) + 2;
        chk("mem_addr", g, mem_addr[g], e.addr);
        chk("mem_wren", g, 16'(mem_wren[g]), 16'(bc[g] == 1 && e.wren));
        if (bc[g] == 1 && e.wren) chk("mem_wdata", g, mem_wdata[g], e.wdata);
        chk("f_ack_timing", g, 16'(f_ack[g]), 16'(bc[g] == el && !e.is_d));
        chk("d_ack_timing", g, 16'(d_ack[g]), 16'(bc[g] == el && e.is_d));
        if (bc[g] >= el) begin
          if (!e.wren) begin
            if (e.is_d) exp_drd[g] = e.rdata; else exp_frd[g] = e.rdata;
          end
          chk("ack_f_rdata", g, f_rdata[g], exp_frd[g]);
          chk("ack_d_rdata", g, d_rdata[g], exp_drd[g]);
          exp_ma[g] = e.addr;
          void'(sbq[g].pop_front());
        end
      end
    end
  end

  function automatic void apply(input int g, inout exp_t e);
    if (e.wren) ref_m[g][e.addr] = e.wdata;
    else        e.rdata = ref_m[g][e.addr];
  endfunction

  // Presents one or two requests together and holds each until its ack.
  task automatic batch(input int g, input bit fv, input logic [15:0] fa,
                       input bit dv, input bit dw, input logic [15:0] da, input logic [15:0] dd);
    exp_t ef, ed;
    bit   first_d, fs, ds;
    int   t;
    ef = '{is_d: 1'b0, wren: 1'b0, addr: fa, wdata: 16'h0, rdata: 16'h0};
    ed = '{is_d: 1'b1, wren: dw, addr: da, wdata: dd, rdata: 16'h0};
    first_d = (fv && dv) ? !last_d[g] : dv;
    if (first_d) begin
      apply(g, ed); sbq[g].push_back(ed);
      if (fv) begin apply(g, ef); sbq[g].push_back(ef); end
    end else begin
      apply(g, ef); sbq[g].push_back(ef);
      if (dv) begin apply(g, ed); sbq[g].push_back(ed); end
    end
    last_d[g] = (fv && dv) ? !first_d : first_d;
    f_req[g] = fv; f_addr[g] = fa;
    d_req[g] = dv; d_wren[g] = dw; d_addr[g] = da; d_wdata[g] = dd;
    t = 0;
    while ((f_req[g] || d_req[g]) && t < 60) begin
      @(negedge clock);
      fs = f_ack[g];
      ds = d_ack[g];
      @(posedge clock);
      #1;
      if (fs) begin f_req[g] = 1'b0; f_addr[g] = 16'($urandom); end
      if (ds) begin d_req[g] = 1'b0; d_addr[g] = 16'($urandom); end
      t++;
    end
    if (f_req[g] || d_req[g]) begin
      n_cmp++;
      n_fail++;
      $display("FAIL batch_timeout lane%0d: f_req=%0b d_req=%0b still pending after %0d cycles, required both acked",
               g, f_req[g], d_req[g], t);
      f_req[g] = 1'b0;
      d_req[g] = 1'b0;
      sbq[g].delete();
    end
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    f_req = '0;
    d_req = '0;
    #1;
    for (int g = 0; g < N; g++) begin
      chk("rst_f_ack", g, 16'(f_ack[g]), 16'd0);
      chk("rst_d_ack", g, 16'(d_ack[g]), 16'd0);
      chk("rst_mem_wren", g, 16'(mem_wren[g]), 16'd0);
      chk("rst_busy", g, 16'(busy[g]), 16'd0);
      chk("rst_mem_addr", g, mem_addr[g], 16'd0);
      chk("rst_mem_wdata", g, mem_wdata[g], 16'd0);
      chk("rst_f_rdata", g, f_rdata[g], 16'd0);
      chk("rst_d_rdata", g, d_rdata[g], 16'd0);
      sbq[g].delete();
      last_d[g]  = 1'b0;
      exp_frd[g] = 16'd0;
      exp_drd[g] = 16'd0;
      exp_ma[g]  = 16'd0;
    end
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    bit   fv, dv;
    reset   = 1'b0;
    f_req   = '0;
    d_req   = '0;
    d_wren  = '0;
    f_addr  = '0;
    d_addr  = '0;
    d_wdata = '0;
    for (int g = 0; g < N; g++) begin
      bc[g] = 0;
      for (int a = 0; a < 65536; a++) ref_m[g][a] = init_val(a);
    end
    do_reset();

    // Directed traffic on the RD_LAT=2 lane.
    batch(0, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0);
    batch(0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h8001, 16'h1234);
    chk("ram_holds_write", 0, gen_lane[0].ram[16'h8001], 16'h1234);
    batch(0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h8001, 16'h0);

    // Mid-cycle reset with non-zero registers, then contention D,F,D,F.
    do_reset();
    batch(0, 1'b1, 16'h0100, 1'b1, 1'b1, 16'h0200, 16'hA5A5);
    batch(0, 1'b1, 16'h0200, 1'b1, 1'b0, 16'h0100, 16'h0);

    // Reset one cycle into WAIT abandons the read without an ack.
    e = '{is_d: 1'b0, wren: 1'b0, addr: 16'h0010, wdata: 16'h0, rdata: 16'h0};
    sbq[0].push_back(e);
    f_req[0]  = 1'b1;
    f_addr[0] = 16'h0010;
    @(posedge clock);
    @(posedge clock);
    @(posedge clock);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("no_ack_after_abort", 0, 16'(f_ack[0]), 16'd0);
      @(posedge clock);
      #1;
    end
    batch(0, 1'b1, 16'h0002, 1'b0, 1'b0, 16'h0, 16'h0);

    // Back-to-back reads on the RD_LAT=1 and RD_LAT=4 lanes.
    for (int g = 1; g < N; g++) begin
      batch(g, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0);
      batch(g, 1'b1, 16'h0041, 1'b0, 1'b0, 16'h0, 16'h0);
      batch(g, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0042, 16'h0);
    end

    // Random mixed traffic on all lanes over a small address pool.
    for (int g = 0; g < N; g++) begin
      for (int k = 0; k < 40; k++) begin
        fv = 1'($urandom_range(0, 1));
        dv = 1'($urandom_range(0, 1));
        if (!fv && !dv) dv = 1'b1;
        batch(g, fv, 16'h0100 + 16'($urandom_range(0, 7)),
              dv, 1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 7)),
              16'($urandom));
      end
    end

    repeat (4) @(posedge clock);
    for (int g = 0; g < N; g++) chk("scoreboard_drained", g, 16'(sbq[g].size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
